// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: packet layout, address fields, port indices.
package noc_pkg;

  localparam int PKT_W    = 32;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 8;

  // Destination address is {x[7:4], y[3:0]}
  localparam int X_MSB = 7;
  localparam int X_LSB = 4;
  localparam int Y_MSB = 3;
  localparam int Y_LSB = 0;

  typedef logic [PKT_W-1:0]  packet_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Router input/output port indices
  localparam int SOUTH = 0;
  localparam int EAST  = 1;
  localparam int WEST  = 2;
  localparam int LOCAL = 3;
  localparam int NORTH = 4;

  // Extract the destination address from the low bits of a packet
  function automatic addr_t pkt_addr(input packet_t pkt);
    return pkt[ADDR_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/input_port_fifo.sv
// Per-port input buffer of the mesh router. Holds arriving packets, presents
// the head packet and its destination address to the controller, pops on
// crossbar grant and reports full back upstream.
module input_port_fifo
  import noc_pkg::*;
#(
  parameter int PKT_W = noc_pkg::PKT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PKT_W-1:0]         data_i,
  input  logic                     valid_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [PKT_W-1:0]         packet_o,
  output logic [ADDR_W-1:0]        packet_addr_o,
  output logic                     packet_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full;
  logic             push, pop;
  logic [PKT_W-1:0] head;

  // Flags decode only from registered pointers: no path from valid_i/pop_i
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign push = valid_i && !full;
  assign pop  = pop_i && !empty;

  fifo_mem #(.DEPTH(DEPTH), .WIDTH(PKT_W), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_i),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // Pointer and sticky overflow update; reset discards anything queued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (valid_i && full) overflow_o <= 1'b1;
    end
  end

  // Occupancy falls out of the modulo-2*DEPTH pointer difference
  assign count_o        = wr_ptr - rd_ptr;
  assign full_o         = full;
  assign packet_valid_o = !empty;

  // Head is forced to zero when empty so the controller never sees stale data
  assign packet_o      = empty ? '0 : head;
  assign packet_addr_o = packet_o[ADDR_LSB +: ADDR_W];

endmodule

// File: doc/input_port_fifo.md
Name: input_port_fifo

Overview:
- Per-port input buffer of the mesh router; one instance per input direction (N/S/E/W/L).
- Stores arriving packets and presents the head packet's 8-bit destination address and valid to the route-compute/arbitration controller.
- Pops the head when the crossbar grant selects this port.
- Drives full back to the upstream neighbour router, where it is consumed as that router's buffer_full_in bit.

Parameters:
- PKT_W, 32, packet width in bits; bits [7:0] are the destination address ({x[7:4], y[3:0]}).
- DEPTH, 4, number of packet entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_i  input  PKT_W  incoming packet from the upstream link.
- valid_i  input  1  data_i is valid this cycle.
- full_o  output  1  no free entry; upstream must not send.
- pop_i  input  1  head packet granted and forwarded this cycle.
- packet_o  output  PKT_W  head packet to the crossbar.
- packet_addr_o  output  8  head packet bits [7:0], to the controller.
- packet_valid_o  output  1  FIFO non-empty (head valid).
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- overflow_o  output  1  sticky error: write attempted while full.

Behaviour:
- Reset: rd_ptr=0, wr_ptr=0, count_o=0, packet_valid_o=0, full_o=0, overflow_o=0, packet_o=0, packet_addr_o=0.
  - Storage array is not reset.
  - rst overrides all other inputs in the same cycle, including mid-stream; queued packets are discarded.
- Pointers are $clog2(DEPTH)+1 bits wide, using an extra wrap bit.
  - empty when pointers are equal.
  - full when the index bits are equal and the wrap bits differ.
  - Both pointers increment modulo 2*DEPTH.
- full_o = (count == DEPTH) and packet_valid_o = (count != 0). Both are decoded from registered state: no combinational path from valid_i or pop_i.
- Push: valid_i && !full_o stores data_i at wr_ptr on the rising edge and increments wr_ptr.
- Pop: pop_i && packet_valid_o increments rd_ptr. pop_i while empty is ignored, with no state change.
- Push and pop in the same cycle on a non-empty, non-full FIFO: both occur, count unchanged.
- Push and pop in the same cycle while full: the pop occurs but the push is dropped, because full_o was high. overflow_o sets if valid_i was high.
- Push and pop in the same cycle while empty: the pop is ignored and the push occurs, so count becomes 1.
- valid_i while full_o: data dropped, overflow_o sets to 1 and stays set until rst.
- Latency: a packet written at edge N appears on packet_o and packet_valid_o after edge N, i.e. it can be granted in cycle N+1. There is no write-to-read bypass.
- packet_o and packet_addr_o show mem[rd_ptr] when non-empty and are forced to 0 when empty. The controller therefore never sees X addresses.
- Order is strict FIFO; no reordering and no priority.

Decomposition:
- Shared package noc_pkg contains:
  - PKT_W default.
  - ADDR_LSB=0 and ADDR_W=8.
  - X_MSB=7, X_LSB=4, Y_MSB=3, Y_LSB=0.
  - typedef packet_t (logic [PKT_W-1:0]).
  - typedef addr_t (logic [7:0]).
  - Port index constants: SOUTH=0, EAST=1, WEST=2, LOCAL=3, NORTH=4.
- One sub-module, fifo_mem: DEPTH x PKT_W register array with one write port and one asynchronous read port.
- Pointer, count and flag logic stays in input_port_fifo.

Test Plan (DEPTH=4, PKT_W=32):
- Reset, then idle: count_o=0, packet_valid_o=0, full_o=0, packet_o=0, overflow_o=0. pop_i=1 on empty: no change.
- Push 0xAAAA0012: the next cycle shows packet_valid_o=1, packet_addr_o=0x12, count_o=1. Pop: packet_valid_o=0 and packet_o=0 the next cycle.
- Push 0x11,0x22,0x33,0x44 back to back: full_o=1 after the fourth edge, count_o=4. A fifth push of 0x55 is dropped and overflow_o=1. Pops return 0x11,0x22,0x33,0x44 in order, and overflow_o stays 1.
- With count=2, assert push and pop together for 10 cycles using ascending data: count_o stays 2. Heads come out in push order, with correct pointer wrap across entries 3->0.
- When full, assert push 0x66 and pop together: head 0x11 is removed, 0x66 is not stored, count_o=3, overflow_o=1.
- With 3 entries queued, assert rst for one cycle while valid_i=1: the next cycle shows count_o=0, packet_valid_o=0, overflow_o=0, and the pushed data was not stored.
